// File: rtl/reg_share_arbiter_if.sv
// Bus between the requesters and the shared-register arbiter.
// Handshake: a requester holds req[i] and its wdata slice stable until gnt[i]=1;
// gnt[i]=1 means that data is already in q. Keeping req[i] high queues another write.
interface reg_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [PW-1:0]         q_owner;
  logic                  valid;

  modport master (output req, wdata, input gnt, q, q_owner, valid);
  modport slave  (input req, wdata, output gnt, q, q_owner, valid);
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register.
// Optional owner bursts of up to MAX_BURST captures when ARB_BURST_EN is defined.
module reg_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_share_arbiter_if.slave   bus,
  output logic                 fsm_state
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, mask, elig;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [PW-1:0]     owner_q, owner_d, ptr_q, ptr_d, win;
  logic              valid_q, valid_d, any;

`ifdef ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold;

  // The current owner stays unmasked and keeps priority until its burst is used up.
  assign hold = (|gnt_q) && bus.req[owner_q] && (cnt_q < CW'(MAX_BURST));
  assign mask = hold ? '0 : gnt_q;
`else
  assign mask = gnt_q;
`endif

  assign elig = bus.req & ~mask;

  // First eligible requester searching ptr, ptr+1, ..., wrapping around.
  always_comb begin
    int idx;
    idx = 0;
    win = ptr_q;
    any = 1'b0;
`ifdef ARB_BURST_EN
    if (hold) begin
      win = owner_q;
      any = 1'b1;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && elig[idx]) begin
        any = 1'b1;
        win = PW'(idx);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any ? GRANT : IDLE;
      GRANT:   state_d = any ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output / datapath next values
  always_comb begin
    gnt_d   = '0;
    q_d     = q_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    if (state_d == GRANT) begin
      gnt_d   = NREQ'(1) << win;
      q_d     = bus.wdata[win*WIDTH +: WIDTH];
      owner_d = win;
      valid_d = 1'b1;
      ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

`ifdef ARB_BURST_EN
  always_comb begin
    cnt_d = '0;
    if (any) cnt_d = hold ? cnt_q + 1'b1 : CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.q       = q_q;
  assign bus.q_owner = owner_q;
  assign bus.valid   = valid_q;
  assign fsm_state   = state_q;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed plus random bench for reg_share_arbiter against a round-robin reference model.
module tb_reg_share_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int MB = 3;
`ifdef ARB_BURST_EN
  localparam int MB_EFF = MB;
`else
  localparam int MB_EFF = 1;
`endif

  logic clk;
  logic reset;
  logic fsm_state;

  reg_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  reg_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  // scoreboard: {gnt, q, q_owner, valid}
  logic [14:0] exp_q[$];

  // reference model state
  int         m_ptr, m_last, m_cnt, m_owner;
  logic [7:0] m_q;
  logic       m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_cnt = 0; m_owner = 0; m_q = '0; m_valid = 1'b0;
    exp_q.delete();
  endtask

  // One edge of the arbitration rules: burst owner first, else rotate from ptr skipping last winner.
  task automatic model_edge(input logic [3:0] r, input logic [31:0] wd);
    int w;
    logic [3:0] g;
    w = -1;
    if (m_last >= 0 && r[m_last] && m_cnt < MB_EFF) w = m_last;
    else begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (w < 0 && r[c] && c != m_last) w = c;
      end
    end
    g = 4'b0000;
    if (w >= 0) begin
      m_q = wd[w*8 +: 8];
      m_owner = w;
      m_valid = 1'b1;
      m_ptr = (w + 1) % NREQ;
      m_cnt = (w == m_last) ? m_cnt + 1 : 1;
      m_last = w;
      g[w] = 1'b1;
    end else begin
      m_last = -1;
      m_cnt = 0;
    end
    exp_q.push_back({g, m_q, 2'(m_owner), m_valid});
  endtask

  task automatic check_model();
    logic [14:0] e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("gnt", bus.gnt, e[14:11]);
      chk("q", bus.q, e[10:3]);
      chk("q_owner", bus.q_owner, e[2:1]);
      chk("valid", bus.valid, e[0]);
      chk("gnt_onehot0", $onehot0(bus.gnt), 1);
    end
  endtask

  // driver: apply inputs at negedge, check #1 after the following posedge
  task automatic step(input logic [3:0] r, input logic [31:0] wd);
    @(negedge clk);
    bus.req = r;
    bus.wdata = wd;
    model_edge(r, wd);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_q"}, bus.q, 0);
    chk({tag, "_owner"}, bus.q_owner, 0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_state"}, fsm_state, 0);
  endtask

  // Mid-cycle async reset held 3 cycles, released at a negedge with r/wd already applied.
  task automatic do_reset(input logic [3:0] r, input logic [31:0] wd);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_cleared("rst_async");
    repeat (3) begin
      @(negedge clk);
      check_cleared("rst_hold");
    end
    model_reset();
    bus.req = r;
    bus.wdata = wd;
    reset = 1'b1;
    model_edge(r, wd);
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    reset = 1'b0;
    bus.req = '0;
    bus.wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // some writes before the first reset check
    step(4'b0110, 32'h44332211);
    step(4'b0110, 32'h44332211);

    // async reset, then single requester
    do_reset(4'b0001, 32'h000000A5);
`ifndef ARB_BURST_EN
    chk("t2_e1_gnt", bus.gnt, 4'b0001);
    chk("t2_e1_q", bus.q, 8'hA5);
    chk("t2_e1_owner", bus.q_owner, 0);
    chk("t2_e1_valid", bus.valid, 1);
`endif
    step(4'b0001, 32'h000000A5);
`ifndef ARB_BURST_EN
    chk("t2_e2_gnt", bus.gnt, 4'b0000);
    chk("t2_e2_valid", bus.valid, 1);
`endif
    step(4'b0001, 32'h000000A5);
`ifndef ARB_BURST_EN
    chk("t2_e3_gnt", bus.gnt, 4'b0001);
`endif

    // full contention
    do_reset(4'b1111, 32'h13121110);
`ifndef ARB_BURST_EN
    chk("t3_g0", bus.gnt, 4'b0001); chk("t3_q0", bus.q, 8'h10);
`endif
    step(4'b1111, 32'h13121110);
`ifndef ARB_BURST_EN
    chk("t3_g1", bus.gnt, 4'b0010); chk("t3_q1", bus.q, 8'h11);
`endif
    step(4'b1111, 32'h13121110);
`ifndef ARB_BURST_EN
    chk("t3_g2", bus.gnt, 4'b0100); chk("t3_q2", bus.q, 8'h12);
`endif
    step(4'b1111, 32'h13121110);
`ifndef ARB_BURST_EN
    chk("t3_g3", bus.gnt, 4'b1000); chk("t3_q3", bus.q, 8'h13);
`endif
    step(4'b1111, 32'h13121110);
`ifndef ARB_BURST_EN
    chk("t3_g4", bus.gnt, 4'b0001); chk("t3_q4", bus.q, 8'h10);
`endif

    // wrap and skip: last grant to 3, then req=1010
    do_reset(4'b1111, 32'h13121110);
    step(4'b1111, 32'h13121110);
    step(4'b1111, 32'h13121110);
    step(4'b1111, 32'h13121110);
    step(4'b1010, 32'hD0C0B0A0);
`ifndef ARB_BURST_EN
    chk("t4_g0", bus.gnt, 4'b0010); chk("t4_o0", bus.q_owner, 1);
`endif
    step(4'b1010, 32'hD0C0B0A0);
`ifndef ARB_BURST_EN
    chk("t4_g1", bus.gnt, 4'b1000); chk("t4_o1", bus.q_owner, 3);
`endif
    step(4'b1010, 32'hD0C0B0A0);
`ifndef ARB_BURST_EN
    chk("t4_g2", bus.gnt, 4'b0010);
`endif

    // reset mid-operation
    do_reset(4'b1111, 32'h13121110);
    step(4'b1111, 32'h13121110);
    do_reset(4'b1111, 32'h13121110);
    chk("t5_first_gnt", bus.gnt, 4'b0001);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      step(4'($urandom_range(0, 15)), $urandom);
    end

`ifdef ARB_BURST_EN
    // owner bursts of MB captures
    do_reset(4'b0000, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      step(4'b0011, {16'h0, 8'(8'h20 + k), 8'(k)});
      if (k <= 3) begin
        chk("t6_burst0_gnt", bus.gnt, 4'b0001);
        chk("t6_burst0_q", bus.q, k);
      end else if (k <= 6) begin
        chk("t6_burst1_gnt", bus.gnt, 4'b0010);
      end else begin
        chk("t6_back_gnt", bus.gnt, 4'b0001);
      end
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
Round-robin write arbiter for one shared WIDTH-bit register built from reset-able D flip-flops. NREQ requesters compete for the right to load the register. Each cycle the arbiter picks at most one winner, captures that requester's data into the register, and returns a one-cycle grant as the capture acknowledge. It sits between the requesting blocks and the shared flop bank and sequences every write to it.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, shared register width in bits
MAX_BURST, 4, max consecutive captures per owner (used only when ARB_BURST_EN is defined)

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester write request, level-held
wdata  input  NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
gnt  output  NREQ  registered one-hot capture acknowledge, all-zero when idle
q  output  WIDTH  shared register contents
q_owner  output  $clog2(NREQ)  index of last requester written into q
valid  output  1  high once q has been written since reset

Behaviour:
- Reset: reset=0 immediately (no clock edge needed) forces gnt=0, q=0, q_owner=0, valid=0, rr pointer ptr=0, burst count=0, FSM=IDLE. Takes precedence over all events. All requests in flight are dropped, and requesters must re-request.
- Eligibility at each posedge: elig = req & ~mask, where mask = gnt (the requester acked this cycle is excluded for one edge).
- Winner w is the first set bit of elig searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
- If elig != 0 at the edge: q<=wdata[w], q_owner<=w, gnt<=onehot(w), valid<=1, ptr<=(w+1) mod NREQ, FSM->GRANT.
- If elig == 0 at the edge: gnt<=0, q, q_owner and ptr hold, FSM->IDLE.
- Latency: data is sampled on the same edge that req is seen. gnt is high during the following cycle, and q shows the data in that cycle.
- Handshake: the requester holds req and wdata stable until it sees gnt[i]=1. gnt[i]=1 means the data is already in q. Dropping req in the gnt cycle ends the transaction. Holding req queues a new write, which becomes eligible one edge later.
- FSM states:
  - IDLE (gnt=0).
  - GRANT (gnt one-hot).
  - IDLE->GRANT on elig != 0. GRANT->GRANT on elig != 0. GRANT->IDLE on elig == 0.
- With continuous multiple requesters, grants are back-to-back with no idle cycle.
- ptr wrap: after a grant to NREQ-1, ptr=0.
- A requester that never deasserts still waits at most NREQ-1 grants between services (no starvation).
- req bits dropped before their grant are simply not serviced. No error is flagged.
- gnt is never more than one-hot. valid never returns to 0 except on reset.

Optional Feature:
Macro: ARB_BURST_EN
- Defined: the current owner is not masked while its burst count < MAX_BURST. It keeps winning, capturing new wdata every edge with gnt held high, and the count increments per capture. At count==MAX_BURST, or when the owner drops req, the owner is masked for one edge, ptr advances, and the count clears. A new owner starts at count=1.
- Undefined: behaviour is exactly as above, equivalent to MAX_BURST=1, and no burst counter is synthesised.

Test Plan:
1. Async reset: after writes, drive reset=0 mid-cycle -> gnt=0000, q=0x00, q_owner=0, valid=0 before the next posedge. They stay there while reset=0.
2. Single requester: req=0001, wdata0=0xA5 held from reset release -> edge1 gives gnt=0001, q=0xA5, q_owner=0, valid=1. Edge2 gives gnt=0000 (masked). Edge3 gives gnt=0001 again.
3. Full contention: req=1111, wdata[i]=0x10+i, ptr=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with q=0x10, 0x11, 0x12, 0x13, 0x10.
4. Wrap and skip: last grant to 3 (ptr=0), then req=1010 -> gnt=0010 (q_owner=1), then gnt=1000 (q_owner=3), then 0010.
5. Reset mid-operation: req=1111 for 2 grants, pulse reset=0 for 3 cycles, release with req=1111 -> outputs cleared during reset, first grant after release is gnt=0001.
6. ARB_BURST_EN, MAX_BURST=3: req=0011, wdata0 increments 0x01, 0x02, 0x03 per cycle -> gnt=0001 for 3 cycles with q=0x01, 0x02, 0x03, then gnt=0010 for 3 cycles, then back to 0001.
